// File: rtl/hdmi_frame_monitor.sv
// HDMI receive-side frame monitor: measures line length, line count and a rotating
// XOR signature per frame, with sticky resolution error flags.
module hdmi_frame_monitor #(
  parameter int H_RES  = 64,
  parameter int V_RES  = 64,
  parameter int DATA_W = 32,
  parameter bit VS_INV = 1'b1
) (
  input  logic              hdmi_clk,
  input  logic              hdmi_rst_n,
  input  logic              hdmi_vs,
  input  logic              hdmi_de,
  input  logic [DATA_W-1:0] hdmi_data,
  input  logic              err_clr,
  output logic              frame_valid,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       line_len,
  output logic [15:0]       line_num,
  output logic [31:0]       frame_chk,
  output logic              err_hres,
  output logic              err_vres
);

  typedef enum logic {SYNC_WAIT, FRAME} state_e;

  state_e      state_q, state_d;
  logic        vs_q, de_q;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic [15:0] lin_cnt_q, lin_cnt_d;
  logic [31:0] sig_q, sig_d;
  logic        fv_q, fv_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] line_len_q, line_len_d;
  logic [15:0] line_num_q, line_num_d;
  logic [31:0] frame_chk_q, frame_chk_d;
  logic        err_hres_q, err_hres_d;
  logic        err_vres_q, err_vres_d;
  logic        hres_set, vres_set;

  logic        vs_i, fs, le, in_frame;
  logic [23:0] pixel;
  logic        unused_data;

  assign vs_i        = hdmi_vs ^ VS_INV;
  assign fs          = vs_i & ~vs_q;
  assign le          = ~hdmi_de & de_q;
  assign in_frame    = (state_q == FRAME);
  assign pixel       = hdmi_data[23:0];
  assign unused_data = ^hdmi_data;

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    lin_cnt_d   = lin_cnt_q;
    sig_d       = sig_q;
    fv_d        = 1'b0;
    frame_cnt_d = frame_cnt_q;
    line_len_d  = line_len_q;
    line_num_d  = line_num_q;
    frame_chk_d = frame_chk_q;
    hres_set    = 1'b0;
    vres_set    = 1'b0;

    if (fs) begin
      // A pixel on the FS cycle already belongs to the new frame; an open line is dropped.
      state_d   = FRAME;
      lin_cnt_d = 16'd0;
      pix_cnt_d = hdmi_de ? 16'd1 : 16'd0;
      sig_d     = hdmi_de ? {8'h00, pixel} : 32'd0;
      if (in_frame) begin
        line_num_d  = lin_cnt_q;
        frame_chk_d = sig_q;
        frame_cnt_d = frame_cnt_q + 16'd1;
        fv_d        = 1'b1;
        vres_set    = (lin_cnt_q != 16'(V_RES));
        hres_set    = de_q;
      end
    end else if (in_frame) begin
      if (hdmi_de) begin
        pix_cnt_d = (pix_cnt_q == 16'hFFFF) ? pix_cnt_q : pix_cnt_q + 16'd1;
        sig_d     = {sig_q[30:0], sig_q[31]} ^ {8'h00, pixel};
      end
      if (le) begin
        line_len_d = pix_cnt_q;
        hres_set   = (pix_cnt_q != 16'(H_RES));
        lin_cnt_d  = (lin_cnt_q == 16'hFFFF) ? lin_cnt_q : lin_cnt_q + 16'd1;
        pix_cnt_d  = 16'd0;
      end
    end

    err_hres_d = hres_set | (err_hres_q & ~err_clr);
    err_vres_d = vres_set | (err_vres_q & ~err_clr);
  end

  // vs_q resets high so a sync already active at reset release is not an edge.
  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      state_q     <= SYNC_WAIT;
      vs_q        <= 1'b1;
      de_q        <= 1'b0;
      pix_cnt_q   <= 16'd0;
      lin_cnt_q   <= 16'd0;
      sig_q       <= 32'd0;
      fv_q        <= 1'b0;
      frame_cnt_q <= 16'd0;
      line_len_q  <= 16'd0;
      line_num_q  <= 16'd0;
      frame_chk_q <= 32'd0;
      err_hres_q  <= 1'b0;
      err_vres_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_q        <= vs_i;
      de_q        <= hdmi_de;
      pix_cnt_q   <= pix_cnt_d;
      lin_cnt_q   <= lin_cnt_d;
      sig_q       <= sig_d;
      fv_q        <= fv_d;
      frame_cnt_q <= frame_cnt_d;
      line_len_q  <= line_len_d;
      line_num_q  <= line_num_d;
      frame_chk_q <= frame_chk_d;
      err_hres_q  <= err_hres_d;
      err_vres_q  <= err_vres_d;
    end
  end

  assign frame_valid = fv_q;
  assign frame_cnt   = frame_cnt_q;
  assign line_len    = line_len_q;
  assign line_num    = line_num_q;
  assign frame_chk   = frame_chk_q;
  assign err_hres    = err_hres_q;
  assign err_vres    = err_vres_q;

endmodule

// File: tb/tb_hdmi_frame_monitor.sv
// Directed bench: an active-low-VS and an active-high-VS monitor driven by the same
// video stream, both held to the same hand-derived expectations.
module tb_hdmi_frame_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsAct;
  logic        de;
  logic        clr;
  logic [31:0] data;

  logic        aFv, bFv, aHres, bHres, aVres, bVres;
  logic [15:0] aFcnt, bFcnt, aLen, bLen, aNum, bNum;
  logic [31:0] aChk, bChk;

  int          checks   = 0;
  int          failures = 0;
  int          fvA      = 0;
  int          fvB      = 0;
  logic [31:0] modelSig = 32'd0;
  logic [31:0] savedSig = 32'd0;

  always #5 clk = ~clk;

  hdmi_frame_monitor #(.H_RES(64), .V_RES(64), .DATA_W(32), .VS_INV(1'b1)) dutA (
    .hdmi_clk(clk), .hdmi_rst_n(rst_n), .hdmi_vs(~vsAct), .hdmi_de(de),
    .hdmi_data(data), .err_clr(clr), .frame_valid(aFv), .frame_cnt(aFcnt),
    .line_len(aLen), .line_num(aNum), .frame_chk(aChk),
    .err_hres(aHres), .err_vres(aVres));

  hdmi_frame_monitor #(.H_RES(64), .V_RES(64), .DATA_W(32), .VS_INV(1'b0)) dutB (
    .hdmi_clk(clk), .hdmi_rst_n(rst_n), .hdmi_vs(vsAct), .hdmi_de(de),
    .hdmi_data(data), .err_clr(clr), .frame_valid(bFv), .frame_cnt(bFcnt),
    .line_len(bLen), .line_num(bNum), .frame_chk(bChk),
    .err_hres(bHres), .err_vres(bVres));

  // Pulse counters sample the pre-edge value, so each one-cycle pulse counts once.
  always @(posedge clk) begin
    if (aFv) fvA++;
    if (bFv) fvB++;
  end

  function automatic logic [23:0] pixVal(input int l, input int p);
    logic [7:0] lb, pb;
    lb = 8'(l);
    pb = 8'(p);
    return {lb, pb, lb ^ pb};
  endfunction

  function automatic logic [31:0] sigStep(input logic [31:0] s, input logic [23:0] px);
    return {s[30:0], s[31]} ^ {8'h00, px};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkPair(input string tag, input logic [31:0] obsA, input logic [31:0] obsB,
                           input logic [31:0] exp);
    checkOutput({tag, "_inv1"}, obsA, exp);
    checkOutput({tag, "_inv0"}, obsB, exp);
  endtask

  task automatic checkAllZero(input string tag);
    checkPair({tag, "_fv"},   32'(aFv),   32'(bFv),   32'd0);
    checkPair({tag, "_fcnt"}, 32'(aFcnt), 32'(bFcnt), 32'd0);
    checkPair({tag, "_len"},  32'(aLen),  32'(bLen),  32'd0);
    checkPair({tag, "_num"},  32'(aNum),  32'(bNum),  32'd0);
    checkPair({tag, "_chk"},  aChk,       bChk,       32'd0);
    checkPair({tag, "_hres"}, 32'(aHres), 32'(bHres), 32'd0);
    checkPair({tag, "_vres"}, 32'(aVres), 32'(bVres), 32'd0);
  endtask

  // One clock per call: inputs change on the falling edge, results are read on the next one.
  task automatic applyStimulus(input logic v, input logic d, input logic [23:0] px, input logic c);
    vsAct = v;
    de    = d;
    data  = {8'hA5, px};
    clr   = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sendLine(input int l, input int n);
    for (int p = 0; p < n; p++) begin
      modelSig = sigStep(modelSig, pixVal(l, p));
      applyStimulus(1'b0, 1'b1, pixVal(l, p), 1'b0);
    end
    repeat (3) applyStimulus(1'b0, 1'b0, 24'd0, 1'b0);
  endtask

  task automatic doFS(input logic expValid);
    savedSig = modelSig;
    modelSig = 32'd0;
    applyStimulus(1'b1, 1'b0, 24'd0, 1'b0);
    checkPair("fs_valid", 32'(aFv), 32'(bFv), 32'(expValid));
    applyStimulus(1'b1, 1'b0, 24'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 24'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    vsAct = 1'b1;
    de    = 1'b0;
    clr   = 1'b0;
    data  = 32'd0;
    #23;
    checkAllZero("reset");

    // Sync held active across reset release must not look like a frame start.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) applyStimulus(1'b1, 1'b0, 24'd0, 1'b0);
    sendLine(0, 10);
    checkPair("syncwait_len",  32'(aLen),  32'(bLen),  32'd0);
    checkPair("syncwait_fcnt", 32'(aFcnt), 32'(bFcnt), 32'd0);

    // Frame A: first FS out of SYNC_WAIT reports nothing.
    doFS(1'b0);
    for (int l = 0; l < 64; l++) sendLine(l, 64);
    checkPair("a_len",  32'(aLen),  32'(bLen),  32'd64);
    checkPair("a_hres", 32'(aHres), 32'(bHres), 32'd0);
    checkPair("a_pulses", 32'(fvA), 32'(fvB), 32'd0);

    // Frame B closes frame A.
    doFS(1'b1);
    checkPair("b_fcnt", 32'(aFcnt), 32'(bFcnt), 32'd1);
    checkPair("b_num",  32'(aNum),  32'(bNum),  32'd64);
    checkPair("b_chk",  aChk,       bChk,       savedSig);
    checkPair("b_vres", 32'(aVres), 32'(bVres), 32'd0);
    for (int l = 0; l < 64; l++) sendLine(l, 64);

    // Frame C: 65 lines, line 5 one pixel short.
    doFS(1'b1);
    checkPair("c_fcnt",   32'(aFcnt), 32'(bFcnt), 32'd2);
    checkPair("c_chk",    aChk,       bChk,       savedSig);
    checkPair("c_pulses", 32'(fvA),   32'(fvB),   32'd2);
    for (int l = 0; l < 65; l++) begin
      sendLine(l, (l == 5) ? 63 : 64);
      if (l == 5) begin
        checkPair("short_len",  32'(aLen),  32'(bLen),  32'd63);
        checkPair("short_hres", 32'(aHres), 32'(bHres), 32'd1);
        applyStimulus(1'b0, 1'b0, 24'd0, 1'b1);
        checkPair("clr_hres",   32'(aHres), 32'(bHres), 32'd0);
      end
    end

    // Frame D closes the 65-line frame.
    doFS(1'b1);
    checkPair("d_num",  32'(aNum),  32'(bNum),  32'd65);
    checkPair("d_vres", 32'(aVres), 32'(bVres), 32'd1);
    checkPair("d_fcnt", 32'(aFcnt), 32'(bFcnt), 32'd3);
    checkPair("d_chk",  aChk,       bChk,       savedSig);
    checkPair("d_len",  32'(aLen),  32'(bLen),  32'd64);
    checkPair("d_hres", 32'(aHres), 32'(bHres), 32'd0);
    applyStimulus(1'b0, 1'b0, 24'd0, 1'b1);
    checkPair("clr_vres", 32'(aVres), 32'(bVres), 32'd0);

    // Two full lines, then a line left open when the next sync edge arrives.
    sendLine(0, 64);
    sendLine(1, 64);
    for (int p = 0; p < 5; p++) begin
      modelSig = sigStep(modelSig, pixVal(2, p));
      applyStimulus(1'b0, 1'b1, pixVal(2, p), 1'b0);
    end
    savedSig = modelSig;
    modelSig = sigStep(32'd0, pixVal(0, 0));
    applyStimulus(1'b1, 1'b1, pixVal(0, 0), 1'b0);
    checkPair("open_fv",   32'(aFv),   32'(bFv),   32'd1);
    checkPair("open_hres", 32'(aHres), 32'(bHres), 32'd1);
    checkPair("open_num",  32'(aNum),  32'(bNum),  32'd2);
    checkPair("open_chk",  aChk,       bChk,       savedSig);
    checkPair("open_len",  32'(aLen),  32'(bLen),  32'd64);
    checkPair("open_fcnt", 32'(aFcnt), 32'(bFcnt), 32'd4);
    for (int q = 1; q < 64; q++) begin
      modelSig = sigStep(modelSig, pixVal(0, q));
      applyStimulus((q == 1), 1'b1, pixVal(0, q), (q == 1));
    end
    checkPair("open_clr", 32'(aHres), 32'(bHres), 32'd0);
    applyStimulus(1'b0, 1'b0, 24'd0, 1'b0);
    checkPair("first_px_len",  32'(aLen),  32'(bLen),  32'd64);
    checkPair("first_px_hres", 32'(aHres), 32'(bHres), 32'd0);

    // Reset in the middle of a line clears everything without waiting for a clock.
    applyStimulus(1'b0, 1'b1, pixVal(1, 0), 1'b0);
    applyStimulus(1'b0, 1'b1, pixVal(1, 1), 1'b0);
    #2 rst_n = 1'b0;
    #1 checkAllZero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 24'd0, 1'b0);
    doFS(1'b0);
    checkPair("rst_pulses", 32'(fvA),   32'(fvB),   32'd4);
    checkPair("rst_fcnt",   32'(aFcnt), 32'(bFcnt), 32'd0);

    // Counter wrap on the active-high instance via a preloaded count.
    sendLine(0, 64);
    force dutB.frame_cnt_q = 16'hFFFF;
    applyStimulus(1'b0, 1'b0, 24'd0, 1'b0);
    release dutB.frame_cnt_q;
    checkOutput("preload_inv0", 32'(bFcnt), 32'h0000FFFF);
    doFS(1'b1);
    checkOutput("wrap_fcnt_inv0", 32'(bFcnt), 32'd0);
    checkOutput("wrap_fcnt_inv1", 32'(aFcnt), 32'd1);
    checkPair("wrap_num", 32'(aNum), 32'(bNum), 32'd1);

    $display("[TB] directed sequence complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
